i2s_rx: RTL and testbench

I2S serial-audio receiver. It is the receive end of the I2S link that the core's audio path drives on the I2S_BCK, I2S_LRCK and I2S_DATA pins. It oversamples the three I2S lines in the `clk_sys` domain and reassembles MSB-first words into parallel left/right samples. It serves two uses: the external-ADC audio-in path (cassette input when USE_AUDIO_IN is set) and on-board loopback checking of the transmitter.

---
 rtl/i2s_rx.sv | 143 ++++++++++++++
 tb/tb_i2s_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S serial-audio receiver: oversamples BCK/LRCK/DATA in the clk_sys domain and
// reassembles MSB-first words into left/right sample pairs.
module i2s_rx #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             i2s_bck,
  input  logic             i2s_lrck,
  input  logic             i2s_data,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             strobe,
  output logic             short_frame
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic             bck_s1_q, bck_s2_q, bck_prev_q;
  logic             lr_s1_q, lr_s2_q;
  logic             dat_s1_q, dat_s2_q;

  logic [1:0]       phase_q, phase_d;
  logic             lr_prev_q, lr_prev_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic             have_l_q, have_l_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic             strobe_q, strobe_d;
  logic             short_q, short_d;

  logic             rise;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt_n;
  logic [CW-1:0]    shamt;

  assign rise = bck_s2_q & ~bck_prev_q;

  // Word assembly, alignment and L/R pairing; only advances on a BCK rise.
  always_comb begin
    phase_d   = phase_q;
    lr_prev_d = lr_prev_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    hold_l_d  = hold_l_q;
    have_l_d  = have_l_q;
    left_d    = left_q;
    right_d   = right_q;
    strobe_d  = 1'b0;
    short_d   = 1'b0;
    word      = sr_q;
    cnt_n     = cnt_q;
    shamt     = '0;

    // Bits past WIDTH are dropped; unwritten positions stay 0 for zero fill.
    if (cnt_q < CW'(WIDTH)) begin
      shamt = CW'(WIDTH - 1) - cnt_q;
      word  = sr_q | (WIDTH'(dat_s2_q) << shamt);
      cnt_n = cnt_q + CW'(1);
    end

    if (rise) begin
      if (phase_q == ST_INIT) begin
        lr_prev_d = lr_s2_q;
        phase_d   = ST_ALIGN;
      end else if (lr_s2_q == lr_prev_q) begin
        sr_d  = word;
        cnt_d = cnt_n;
      end else begin
        // Boundary rise: this bit is the LSB of the word just ending.
        if (phase_q == ST_ALIGN) begin
          phase_d = ST_RUN;
        end else begin
          short_d = (cnt_n < CW'(WIDTH));
          if (!lr_prev_q) begin
            hold_l_d = word;
            have_l_d = 1'b1;
          end else if (have_l_q) begin
            left_d   = hold_l_q;
            right_d  = word;
            strobe_d = 1'b1;
            have_l_d = 1'b0;
          end
        end
        sr_d      = '0;
        cnt_d     = '0;
        lr_prev_d = lr_s2_q;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bck_s1_q   <= 1'b0;
      bck_s2_q   <= 1'b0;
      bck_prev_q <= 1'b0;
      lr_s1_q    <= 1'b0;
      lr_s2_q    <= 1'b0;
      dat_s1_q   <= 1'b0;
      dat_s2_q   <= 1'b0;
      phase_q    <= ST_INIT;
      lr_prev_q  <= 1'b0;
      cnt_q      <= '0;
      sr_q       <= '0;
      hold_l_q   <= '0;
      have_l_q   <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      strobe_q   <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      bck_s1_q   <= i2s_bck;
      bck_s2_q   <= bck_s1_q;
      bck_prev_q <= bck_s2_q;
      lr_s1_q    <= i2s_lrck;
      lr_s2_q    <= lr_s1_q;
      dat_s1_q   <= i2s_data;
      dat_s2_q   <= dat_s1_q;
      phase_q    <= phase_d;
      lr_prev_q  <= lr_prev_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      hold_l_q   <= hold_l_d;
      have_l_q   <= have_l_d;
      left_q     <= left_d;
      right_q    <= right_d;
      strobe_q   <= strobe_d;
      short_q    <= short_d;
    end
  end

  assign left        = left_q;
  assign right       = right_q;
  assign strobe      = strobe_q;
  assign short_frame = short_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S slots at BCK = clk_sys/8 and compares committed
// pairs and short-word pulses against a word-level reference model.
module tb_i2s_rx;

  localparam int unsigned W = 16;

  logic         clk_sys = 1'b0;
  logic         reset = 1'b1;
  logic         i2s_bck = 1'b0;
  logic         i2s_lrck = 1'b0;
  logic         i2s_data = 1'b0;
  logic [W-1:0] left, right;
  logic         strobe, short_frame;

  i2s_rx #(.WIDTH(W)) dut (
    .clk_sys(clk_sys), .reset(reset), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck),
    .i2s_data(i2s_data), .left(left), .right(right), .strobe(strobe),
    .short_frame(short_frame)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail = 0;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc++;

  // Output monitor: records strobes and short pulses, flags unexpected output changes.
  logic [2*W-1:0] stb_q[$];
  int unsigned    stb_cyc[$];
  int             sh_cnt = 0;
  int             viol = 0;
  logic [W-1:0]   pl = '0, pr = '0;
  logic           ps = 1'b0, pss = 1'b0;
  always @(negedge clk_sys) begin
    if (reset) begin
      pl = '0; pr = '0; ps = 1'b0; pss = 1'b0;
    end else begin
      if (strobe === 1'b1) begin
        stb_q.push_back({left, right});
        stb_cyc.push_back(cyc);
      end
      if (short_frame === 1'b1) sh_cnt++;
      if ((left !== pl || right !== pr) && strobe !== 1'b1) viol++;
      if ((strobe === 1'b1 && ps) || (short_frame === 1'b1 && pss)) viol++;
      pl = left; pr = right; ps = (strobe === 1'b1); pss = (short_frame === 1'b1);
    end
  end

  // Slot list: channel, payload value, payload length, transmitted length.
  int              s_ch[$];
  longint unsigned s_val[$];
  int              s_len[$];
  int              s_tot[$];
  bit              r_d[$];
  bit              r_lr[$];
  logic [2*W-1:0]  exp_q[$];
  int              exp_sh;
  int              meas_rise = -1;
  int unsigned     meas_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_slots();
    s_ch.delete(); s_val.delete(); s_len.delete(); s_tot.delete();
  endtask

  task automatic add_slot(input int ch, input longint unsigned v, input int len, input int tot);
    s_ch.push_back(ch); s_val.push_back(v); s_len.push_back(len); s_tot.push_back(tot);
  endtask

  // LRCK switches one BCK early, so each slot's last bit carries the next slot's channel.
  task automatic build_rises();
    longint unsigned v;
    r_d.delete(); r_lr.delete();
    for (int k = 0; k < s_ch.size(); k++) begin
      v = s_val[k];
      for (int j = 0; j < s_tot[k]; j++) begin
        r_d.push_back((j < s_len[k]) ? v[s_len[k]-1-j] : 1'b0);
        if (j == s_tot[k] - 1)
          r_lr.push_back((k + 1 < s_ch.size()) ? s_ch[k+1][0] : ~s_ch[k][0]);
        else
          r_lr.push_back(s_ch[k][0]);
      end
    end
  endtask

  // Reference: slot 0 is consumed by alignment; later slots commit first W transmitted bits.
  task automatic run_model();
    longint unsigned full;
    logic [W-1:0]    word, pend;
    bit              have;
    exp_q.delete(); exp_sh = 0; have = 0; pend = '0;
    for (int k = 1; k < s_ch.size(); k++) begin
      full = s_val[k] << (s_tot[k] - s_len[k]);
      if (s_tot[k] >= int'(W)) word = W'(full >> (s_tot[k] - int'(W)));
      else                     word = W'(full << (int'(W) - s_tot[k]));
      if (s_tot[k] < int'(W)) exp_sh++;
      if (s_ch[k] == 0) begin
        pend = word; have = 1;
      end else if (have) begin
        exp_q.push_back({pend, word}); have = 0;
      end
    end
  endtask

  task automatic drive(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk_sys);
      i2s_bck = 1'b0; i2s_data = r_d[i]; i2s_lrck = r_lr[i];
      repeat (3) @(negedge clk_sys);
      i2s_bck = 1'b1;
      if (i == meas_rise) meas_cyc = cyc;
      repeat (4) @(negedge clk_sys);
    end
  endtask

  task automatic idle();
    @(negedge clk_sys);
    i2s_bck = 1'b0;
    repeat (10) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1; i2s_bck = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic check_run(input string tag, input int base_s, input int base_sh);
    int n;
    chk({tag, "_nstrobe"}, 64'(stb_q.size() - base_s), 64'(exp_q.size()));
    n = (stb_q.size() - base_s < exp_q.size()) ? stb_q.size() - base_s : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_pair"}, 64'(stb_q[base_s+i]), 64'(exp_q[i]));
    chk({tag, "_nshort"}, 64'(sh_cnt - base_sh), 64'(exp_sh));
    chk({tag, "_stable"}, 64'(viol), 64'd0);
  endtask

  int bs, bh, cut;
  longint unsigned rv;
  int ln, tt, ch0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_left", 64'(left), 64'd0);
    chk("rst_right", 64'(right), 64'd0);
    chk("rst_strobe", 64'(strobe), 64'd0);
    chk("rst_short", 64'(short_frame), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Standard 16-bit words in 32-BCK slots, plus latency from the last right LSB
    clear_slots();
    add_slot(1, 64'h1234, 16, 32);
    for (int f = 0; f < 3; f++) begin
      add_slot(0, 64'hA5C3, 16, 32);
      add_slot(1, 64'h1234, 16, 32);
    end
    build_rises(); run_model();
    meas_rise = r_d.size() - 1;
    bs = stb_q.size(); bh = sh_cnt;
    drive(0, r_d.size()); idle();
    check_run("std", bs, bh);
    chk("std_left", 64'(left), 64'hA5C3);
    chk("std_right", 64'(right), 64'h1234);
    // Strobe visible in the clk_sys cycle ending at edge N+3 (N = first edge seeing BCK high)
    chk("latency", 64'(stb_cyc[stb_cyc.size()-1]), 64'(meas_cyc + 3));
    meas_rise = -1;

    // Short 12-bit words
    do_reset();
    clear_slots();
    add_slot(1, 64'h123, 12, 12);
    for (int f = 0; f < 3; f++) begin
      add_slot(0, 64'hABC, 12, 12);
      add_slot(1, 64'h123, 12, 12);
    end
    build_rises(); run_model();
    bs = stb_q.size(); bh = sh_cnt;
    drive(0, r_d.size()); idle();
    check_run("short", bs, bh);
    chk("short_left", 64'(left), 64'hABC0);
    chk("short_right", 64'(right), 64'h1230);

    // Long 24-bit words
    do_reset();
    clear_slots();
    add_slot(1, 64'h80FF00, 24, 24);
    for (int f = 0; f < 2; f++) begin
      add_slot(0, 64'h7F00FF, 24, 24);
      add_slot(1, 64'h80FF00, 24, 24);
    end
    build_rises(); run_model();
    bs = stb_q.size(); bh = sh_cnt;
    drive(0, r_d.size()); idle();
    check_run("long", bs, bh);
    chk("long_left", 64'(left), 64'h7F00);
    chk("long_right", 64'(right), 64'h80FF);

    // Randomized word lengths, padding and data, including 1-bit words
    for (int r = 0; r < 3; r++) begin
      do_reset();
      clear_slots();
      ch0 = int'($urandom_range(0, 1));
      for (int k = 0; k < 10; k++) begin
        ln = (k == 3 || k == 6) ? 1 : int'($urandom_range(1, 24));
        tt = ln + (($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : 0);
        if (k == 0 && tt < 2) tt = 2;
        rv = {$urandom, $urandom} & ((64'd1 << ln) - 64'd1);
        add_slot((ch0 + k) % 2, rv, ln, tt);
      end
      build_rises(); run_model();
      bs = stb_q.size(); bh = sh_cnt;
      drive(0, r_d.size()); idle();
      check_run("rand", bs, bh);
    end

    // Reset in the middle of a left word
    do_reset();
    clear_slots();
    add_slot(1, 64'h1111, 16, 32);
    add_slot(0, 64'hBEEF, 16, 32);
    add_slot(1, 64'hCAFE, 16, 32);
    add_slot(0, 64'h7777, 16, 32);
    build_rises(); run_model();
    cut = 96 + 10;
    bs = stb_q.size(); bh = sh_cnt;
    drive(0, cut);
    check_run("pre_rst", bs, bh);
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("midrst_left", 64'(left), 64'd0);
    chk("midrst_right", 64'(right), 64'd0);
    chk("midrst_strobe", 64'(strobe), 64'd0);
    chk("midrst_short", 64'(short_frame), 64'd0);
    i2s_bck = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Restart in the middle of a right word
    clear_slots();
    add_slot(1, 64'h15, 5, 5);
    add_slot(0, 64'h5A5A, 16, 32);
    add_slot(1, 64'h0F0F, 16, 32);
    add_slot(0, 64'hC33C, 16, 32);
    add_slot(1, 64'h3CC3, 16, 32);
    build_rises(); run_model();
    bs = stb_q.size(); bh = sh_cnt;
    drive(0, r_d.size()); idle();
    check_run("restart", bs, bh);
    chk("restart_left", 64'(left), 64'hC33C);
    chk("restart_right", 64'(right), 64'h3CC3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
